// File: rtl/approx_mult4.sv
// 4x4 approximate multiplier: OR-merged columns 0..2, exact columns 3..7, one register stage.
// Define APPROX_ERR_MON_EN to add the exact-product error monitor ports and counters.
module approx_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  output logic [7:0] result,
  output logic [7:0] result_q,
  output logic       out_valid
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [7:0]  exact_q,
  output logic [7:0]  abs_err_q,
  output logic [15:0] err_sum,
  output logic [8:0]  nz_count
`endif
);

  logic       col0;
  logic       col1;
  logic       col2;
  logic [7:0] hi_sum;

  assign col0 = a[0] & b[0];
  assign col1 = (a[1] & b[0]) | (a[0] & b[1]);
  assign col2 = (a[2] & b[0]) | (a[1] & b[1]) | (a[0] & b[2]);

  // Weight >= 3 partial products summed exactly; the low columns never carry.
  always_comb begin
    hi_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i + j >= 3)
          hi_sum = hi_sum + (8'(a[j] & b[i]) << (i + j));
      end
    end
  end

  assign result = hi_sum + {5'b0, col2, col1, col0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid)
        result_q <= result;
    end
  end

`ifdef APPROX_ERR_MON_EN
  logic [7:0]  exact;
  logic [7:0]  diff;
  logic [16:0] sum_ext;

  assign exact   = {4'b0, a} * {4'b0, b};
  assign diff    = exact - result;
  assign sum_ext = {1'b0, err_sum} + {9'b0, diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_q   <= '0;
      abs_err_q <= '0;
      err_sum   <= '0;
      nz_count  <= '0;
    end else if (in_valid) begin
      exact_q   <= exact;
      abs_err_q <= diff;
      if (exact != 8'd0) begin
        err_sum <= sum_ext[16] ? 16'hffff : sum_ext[15:0];
        if (nz_count != 9'h1ff)
          nz_count <= nz_count + 9'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult4.sv
// Directed bench for approx_mult4: sweep, pipeline, back-to-back, async reset.
// Monitor checks are included when APPROX_ERR_MON_EN is defined.
module tb_approx_mult4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [7:0] result;
  logic [7:0] result_q;
  logic       out_valid;
`ifdef APPROX_ERR_MON_EN
  logic [7:0]  exact_q;
  logic [7:0]  abs_err_q;
  logic [15:0] err_sum;
  logic [8:0]  nz_count;
`endif

  int tests;
  int fails;

  approx_mult4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .result    (result),
    .result_q  (result_q),
    .out_valid (out_valid)
`ifdef APPROX_ERR_MON_EN
    ,
    .exact_q   (exact_q),
    .abs_err_q (abs_err_q),
    .err_sum   (err_sum),
    .nz_count  (nz_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product minus the carries the low columns lose.
  function automatic int model(input logic [3:0] x, input logic [3:0] y);
    int c0, c1, c2, lo_ex, lo_ap;
    c0 = int'(x[0] & y[0]);
    c1 = int'(x[1] & y[0]) + int'(x[0] & y[1]);
    c2 = int'(x[2] & y[0]) + int'(x[1] & y[1]) + int'(x[0] & y[2]);
    lo_ex = c0 + 2 * c1 + 4 * c2;
    lo_ap = c0 + 2 * (c1 != 0 ? 1 : 0) + 4 * (c2 != 0 ? 1 : 0);
    return int'(x) * int'(y) - lo_ex + lo_ap;
  endfunction

  task automatic capture(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (result_q !== 8'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset result_q=%0d out_valid=%0b expected 0/0", result_q, out_valid);
    end
`ifdef APPROX_ERR_MON_EN
    tests++;
    if (exact_q !== 8'd0 || abs_err_q !== 8'd0 || err_sum !== 16'd0 || nz_count !== 9'd0) begin
      fails++;
      $display("FAIL reset_mon exact_q=%0d abs_err_q=%0d err_sum=%0d nz=%0d expected 0",
               exact_q, abs_err_q, err_sum, nz_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep;
    int err;
    logic [3:0] da [7] = '{4'd3, 4'd15, 4'd2, 4'd8, 4'd0, 4'd11, 4'd1};
    logic [3:0] db [7] = '{4'd3, 4'd15, 4'd2, 4'd15, 4'd9, 4'd0, 4'd13};
    logic [7:0] de [7] = '{8'd7, 8'd215, 8'd4, 8'd120, 8'd0, 8'd0, 8'd13};
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = 4'(i);
        b = 4'(j);
        #1;
        tests++;
        if (int'(result) !== model(a, b)) begin
          fails++;
          $display("FAIL sweep a=%0d b=%0d result=%0d expected=%0d", i, j, result, model(a, b));
        end
        err = i * j - int'(result);
        tests++;
        if (err < 0 || err > 10) begin
          fails++;
          $display("FAIL err_bound a=%0d b=%0d err=%0d expected 0..10", i, j, err);
        end
      end
    end
    for (int k = 0; k < 7; k++) begin
      a = da[k];
      b = db[k];
      #1;
      tests++;
      if (result !== de[k]) begin
        fails++;
        $display("FAIL directed a=%0d b=%0d result=%0d expected=%0d", a, b, result, de[k]);
      end
    end
  endtask

  task automatic test_pipeline;
    capture(4'd15, 4'd15);
    tests++;
    if (result_q !== 8'd215 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pipe_load result_q=%0d out_valid=%0b expected 215/1", result_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'd2;
    b = 4'd2;
    @(posedge clk);
    #1;
    tests++;
    if (result_q !== 8'd215 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL pipe_hold result_q=%0d out_valid=%0b expected 215/0", result_q, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    capture(4'd3, 4'd3);
    tests++;
    if (result_q !== 8'd7 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first result_q=%0d out_valid=%0b expected 7/1", result_q, out_valid);
    end
    capture(4'd1, 4'd13);
    tests++;
    if (result_q !== 8'd13 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second result_q=%0d out_valid=%0b expected 13/1", result_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    capture(4'd15, 4'd15);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (result_q !== 8'd0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset result_q=%0d out_valid=%0b expected 0/0", result_q, out_valid);
    end
    tests++;
    if (result !== 8'd215) begin
      fails++;
      $display("FAIL reset_comb result=%0d expected=215", result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

`ifdef APPROX_ERR_MON_EN
  task automatic test_monitor;
    logic [3:0] ma [3] = '{4'd3, 4'd15, 4'd0};
    logic [3:0] mb [3] = '{4'd3, 4'd15, 4'd7};
    logic [7:0] me [3] = '{8'd2, 8'd10, 8'd0};
    logic [7:0] mx [3] = '{8'd9, 8'd225, 8'd0};
    for (int k = 0; k < 3; k++) begin
      capture(ma[k], mb[k]);
      tests++;
      if (abs_err_q !== me[k] || exact_q !== mx[k]) begin
        fails++;
        $display("FAIL mon_step%0d abs_err_q=%0d exact_q=%0d expected %0d/%0d",
                 k, abs_err_q, exact_q, me[k], mx[k]);
      end
    end
    tests++;
    if (err_sum !== 16'd12 || nz_count !== 9'd2) begin
      fails++;
      $display("FAIL mon_totals err_sum=%0d nz_count=%0d expected 12/2", err_sum, nz_count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'd15;
    b = 4'd15;
    @(posedge clk);
    #1;
    tests++;
    if (err_sum !== 16'd12 || nz_count !== 9'd2 || abs_err_q !== 8'd0) begin
      fails++;
      $display("FAIL mon_idle err_sum=%0d nz_count=%0d abs_err_q=%0d expected 12/2/0",
               err_sum, nz_count, abs_err_q);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    in_valid = 1'b0;
    test_reset;
    test_sweep;
    test_pipeline;
    test_back_to_back;
    test_async_reset;
`ifdef APPROX_ERR_MON_EN
    test_monitor;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
